// File: rtl/lfsr_prng_if.sv
// Bus bundle for lfsr_prng: step/seed controls in, register contents and seed-match flag out.
interface lfsr_prng_if #(
    parameter int unsigned NUM_BITS = 8
);
    logic                i_Enable;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_Seed_Data;
    logic [NUM_BITS-1:0] o_LFSR_Data;
    logic                o_LFSR_Done;

    modport master (
        output i_Enable,
        output i_Seed_DV,
        output i_Seed_Data,
        input  o_LFSR_Data,
        input  o_LFSR_Done
    );

    modport slave (
        input  i_Enable,
        input  i_Seed_DV,
        input  i_Seed_Data,
        output o_LFSR_Data,
        output o_LFSR_Done
    );
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci XNOR LFSR with loadable seed; o_LFSR_Done flags register == seed.
// Maximal-length tap sets for widths 3..32, 64 and 128.
module lfsr_prng #(
    parameter int unsigned NUM_BITS = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    lfsr_prng_if.slave  bus
);
    localparam int unsigned MAX_BITS = 128;

    function automatic logic [MAX_BITS-1:0] tap(input int unsigned k);
        return MAX_BITS'(1) << (k - 1);
    endfunction

    // Tap k maps to register bit k-1; an all-zero mask marks an unsupported width.
    function automatic logic [MAX_BITS-1:0] tap_mask(input int unsigned n);
        logic [MAX_BITS-1:0] m;
        m = '0;
        case (n)
            3:   m = tap(3)   | tap(2);
            4:   m = tap(4)   | tap(3);
            5:   m = tap(5)   | tap(3);
            6:   m = tap(6)   | tap(5);
            7:   m = tap(7)   | tap(6);
            8:   m = tap(8)   | tap(6)   | tap(5)   | tap(4);
            9:   m = tap(9)   | tap(5);
            10:  m = tap(10)  | tap(7);
            11:  m = tap(11)  | tap(9);
            12:  m = tap(12)  | tap(6)   | tap(4)   | tap(1);
            13:  m = tap(13)  | tap(4)   | tap(3)   | tap(1);
            14:  m = tap(14)  | tap(5)   | tap(3)   | tap(1);
            15:  m = tap(15)  | tap(14);
            16:  m = tap(16)  | tap(15)  | tap(13)  | tap(4);
            17:  m = tap(17)  | tap(14);
            18:  m = tap(18)  | tap(11);
            19:  m = tap(19)  | tap(6)   | tap(2)   | tap(1);
            20:  m = tap(20)  | tap(17);
            21:  m = tap(21)  | tap(19);
            22:  m = tap(22)  | tap(21);
            23:  m = tap(23)  | tap(18);
            24:  m = tap(24)  | tap(23)  | tap(22)  | tap(17);
            25:  m = tap(25)  | tap(22);
            26:  m = tap(26)  | tap(6)   | tap(2)   | tap(1);
            27:  m = tap(27)  | tap(5)   | tap(2)   | tap(1);
            28:  m = tap(28)  | tap(25);
            29:  m = tap(29)  | tap(27);
            30:  m = tap(30)  | tap(6)   | tap(4)   | tap(1);
            31:  m = tap(31)  | tap(28);
            32:  m = tap(32)  | tap(22)  | tap(2)   | tap(1);
            64:  m = tap(64)  | tap(63)  | tap(61)  | tap(60);
            128: m = tap(128) | tap(126) | tap(101) | tap(99);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [MAX_BITS-1:0] TAP_MASK = tap_mask(NUM_BITS);

    generate
        if (TAP_MASK == '0) begin : g_bad_width
            $error("lfsr_prng: unsupported NUM_BITS %0d", NUM_BITS);
        end
    endgenerate

    localparam logic [NUM_BITS-1:0] TAPS = TAP_MASK[NUM_BITS-1:0];

    logic [NUM_BITS-1:0] r_lfsr;
    logic                w_fb;

    // XNOR feedback: all-ones is the lock-up state, zero is legal.
    assign w_fb = ~^(r_lfsr & TAPS);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_lfsr <= '0;
        end else if (bus.i_Enable) begin
            if (bus.i_Seed_DV) begin
                r_lfsr <= bus.i_Seed_Data;
            end else begin
                r_lfsr <= {r_lfsr[NUM_BITS-2:0], w_fb};
            end
        end
    end

    assign bus.o_LFSR_Data = r_lfsr;
    assign bus.o_LFSR_Done = (r_lfsr == bus.i_Seed_Data);
endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng at widths 4, 8 and 128.
module tb_lfsr_prng;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst8, rst128;

    lfsr_prng_if #(.NUM_BITS(4))   if4 ();
    lfsr_prng_if #(.NUM_BITS(8))   if8 ();
    lfsr_prng_if #(.NUM_BITS(128)) if128 ();

    lfsr_prng #(.NUM_BITS(4))   u_dut4   (.i_Clk(clk), .i_Rst(rst4),   .bus(if4));
    lfsr_prng #(.NUM_BITS(8))   u_dut8   (.i_Clk(clk), .i_Rst(rst8),   .bus(if8));
    lfsr_prng #(.NUM_BITS(128)) u_dut128 (.i_Clk(clk), .i_Rst(rst128), .bus(if128));

    typedef struct {
        int unsigned  unit;
        int unsigned  idx;
        logic [127:0] data;
        logic         done;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_push   = 0;

    localparam logic [3:0] SEQ4 [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                         4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    localparam logic [3:0] AFTER9 [15] = '{4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h1, 4'h3,
                                           4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9};
    localparam logic [7:0] SEQ8 [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    localparam logic [127:0] SEED128 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    function automatic logic [127:0] next128(input logic [127:0] p);
        return {p[126:0], ~(p[127] ^ p[125] ^ p[100] ^ p[98])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int unsigned unit, input logic [127:0] data, input logic [127:0] seed);
        exp_t e;
        e.unit = unit;
        e.idx  = n_push;
        e.data = data;
        e.done = (data == seed);
        n_push++;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, compare every pending expectation there.
    always @(negedge clk) begin : mon
        exp_t         e;
        logic [127:0] act_d;
        logic         act_f;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            case (e.unit)
                0:       begin act_d = 128'(if4.o_LFSR_Data); act_f = if4.o_LFSR_Done; end
                1:       begin act_d = 128'(if8.o_LFSR_Data); act_f = if8.o_LFSR_Done; end
                default: begin act_d = if128.o_LFSR_Data;     act_f = if128.o_LFSR_Done; end
            endcase
            n_checks++;
            if (act_d === e.data) n_pass++;
            else $display("FAIL data u%0d #%0d: got %h expected %h", e.unit, e.idx, act_d, e.data);
            n_checks++;
            if (act_f === e.done) n_pass++;
            else $display("FAIL done u%0d #%0d: got %b expected %b", e.unit, e.idx, act_f, e.done);
        end
    end

    initial begin
        logic [127:0] m;
        rst4 = 1'b1; rst8 = 1'b1; rst128 = 1'b1;
        if4.i_Enable = 1'b0;   if4.i_Seed_DV = 1'b0;   if4.i_Seed_Data = 4'h9;
        if8.i_Enable = 1'b0;   if8.i_Seed_DV = 1'b0;   if8.i_Seed_Data = 8'h00;
        if128.i_Enable = 1'b0; if128.i_Seed_DV = 1'b0; if128.i_Seed_Data = '0;

        // Reset state on all three widths
        tick();
        push(0, 128'h0, 128'h9);
        push(1, 128'h0, 128'h0);
        push(2, 128'h0, 128'h0);
        settle();
        rst4 = 1'b0; rst8 = 1'b0; rst128 = 1'b0;

        // Free-running 4-bit sequence from zero
        if4.i_Enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            push(0, 128'(SEQ4[i]), 128'h9);
            settle();
        end

        // Seed 9 load and full period back to the seed
        if4.i_Seed_DV = 1'b1;
        tick();
        push(0, 128'h9, 128'h9);
        settle();
        if4.i_Seed_DV = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            push(0, 128'(AFTER9[i]), 128'h9);
            settle();
        end

        // Seed strobe ignored while disabled
        if4.i_Enable = 1'b0; if4.i_Seed_DV = 1'b1; if4.i_Seed_Data = 4'h3;
        for (int i = 0; i < 5; i++) begin
            tick();
            push(0, 128'h9, 128'h3);
            settle();
        end
        // Done follows the seed input with no enabled edge
        if4.i_Seed_Data = 4'h9;
        #1;
        push(0, 128'h9, 128'h9);
        settle();

        // All-ones lock-up
        if4.i_Enable = 1'b1; if4.i_Seed_DV = 1'b1; if4.i_Seed_Data = 4'hF;
        tick();
        push(0, 128'hF, 128'hF);
        settle();
        if4.i_Seed_DV = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            push(0, 128'hF, 128'hF);
            settle();
        end
        if4.i_Enable = 1'b0;

        // 8-bit: reset mid-sequence overrides enable and seed load
        if8.i_Enable = 1'b1; if8.i_Seed_Data = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            push(1, 128'(SEQ8[i]), 128'hA5);
            settle();
        end
        rst8 = 1'b1; if8.i_Seed_DV = 1'b1;
        tick();
        push(1, 128'h00, 128'hA5);
        settle();
        rst8 = 1'b0; if8.i_Seed_DV = 1'b0;
        tick();
        push(1, 128'h01, 128'hA5);
        settle();
        tick();
        push(1, 128'h03, 128'hA5);
        settle();
        if8.i_Enable = 1'b0;

        // 128-bit: seed load then ten steps against the tap formula
        if128.i_Enable = 1'b1; if128.i_Seed_DV = 1'b1; if128.i_Seed_Data = SEED128;
        tick();
        push(2, SEED128, SEED128);
        settle();
        if128.i_Seed_DV = 1'b0;
        m = SEED128;
        for (int i = 0; i < 10; i++) begin
            m = next128(m);
            tick();
            push(2, m, SEED128);
            settle();
        end
        if128.i_Enable = 1'b0;

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) settle();
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
